cpu_sequencer: RTL and testbench

Multi-cycle fetch/execute controller for the Master CPU datapath. It steps the program counter through instruction RAM, latches each instruction for field decode, and sequences the ALU, memory_control, register bank and data RAM through fetch, execute, memory and writeback. It also arbitrates the single data-RAM port between CPU loads/stores and an external preload port.

---
 rtl/cpu_sequencer_if.sv | 39 +++
 rtl/cpu_sequencer.sv | 132 +++++++++++++
 tb/tb_cpu_sequencer.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_sequencer_if.sv
// Bus bundle between cpu_sequencer (master) and the datapath / RAM environment (slave).
interface cpu_sequencer_if #(
    parameter int PC_W    = 8,
    parameter int DADDR_W = 16
);
    logic               Imem_En;
    logic [PC_W-1:0]    Imem_Addr;
    logic [31:0]        Imem_Data;
    logic [31:0]        Instr;
    logic               Cond_Pass;
    logic [31:0]        Alu_Result;
    logic [31:0]        Store_Data;
    logic               Dmem_En;
    logic               Dmem_RW;
    logic [DADDR_W-1:0] Dmem_Addr;
    logic [31:0]        Dmem_WData;
    logic [31:0]        Dmem_RData;
    logic               Reg_We;
    logic [31:0]        Reg_WData;
    logic               Flag_We;
    logic               Ld_Req;
    logic [DADDR_W-1:0] Ld_Addr;
    logic [31:0]        Ld_Data;
    logic               Ld_Gnt;

    modport master (
        output Imem_En, Imem_Addr, Instr, Dmem_En, Dmem_RW, Dmem_Addr, Dmem_WData,
               Reg_We, Reg_WData, Flag_We, Ld_Gnt,
        input  Imem_Data, Cond_Pass, Alu_Result, Store_Data, Dmem_RData,
               Ld_Req, Ld_Addr, Ld_Data
    );

    modport slave (
        input  Imem_En, Imem_Addr, Instr, Dmem_En, Dmem_RW, Dmem_Addr, Dmem_WData,
               Reg_We, Reg_WData, Flag_We, Ld_Gnt,
        output Imem_Data, Cond_Pass, Alu_Result, Store_Data, Dmem_RData,
               Ld_Req, Ld_Addr, Ld_Data
    );
endinterface

// File: rtl/cpu_sequencer.sv
// Multi-cycle fetch/exec/mem/writeback controller with data-RAM preload arbitration.
// Optional: define CPU_SEQ_BRANCH_EN to make opcode 4'hC a conditional branch (else NOP).
module cpu_sequencer #(
    parameter int PC_W    = 8,
    parameter int DADDR_W = 16,
    parameter int MEM_LAT = 1
) (
    input  logic Clk,
    input  logic Reset_n,
    input  logic Run,
    output logic Halted,
    output logic Busy,
    cpu_sequencer_if.master bus
);
    localparam int CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam logic [CW-1:0] LAST = CW'(MEM_LAT - 1);
    localparam int S_BIT = 23;

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_EXEC, S_MEM, S_WB, S_HALT
    } state_t;

    state_t          state;
    logic [PC_W-1:0] pc;
    logic [PC_W-1:0] pc_next;
    logic [31:0]     instr_q;
    logic [31:0]     reg_wdata;
    logic [CW-1:0]   cnt;
    logic            reg_we;
    logic            flag_we;

    logic [3:0] opcode;
    logic       is_ldr, is_str, is_halt, is_alu, lat_done, cpu_mem, ld_gnt;

    assign opcode   = instr_q[27:24];
    assign is_ldr   = (opcode == 4'hD);
    assign is_str   = (opcode == 4'hE);
    assign is_halt  = (opcode == 4'hF);
    // 4'hC never writes registers or flags, whether it is a branch or a NOP
    assign is_alu   = (opcode[3:2] != 2'b11);
    assign lat_done = (cnt == LAST);

`ifdef CPU_SEQ_BRANCH_EN
    assign pc_next = (opcode == 4'hC && bus.Cond_Pass) ? instr_q[PC_W+2:3] : pc + PC_W'(1);
`else
    assign pc_next = pc + PC_W'(1);
`endif

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state     <= S_IDLE;
            pc        <= '0;
            instr_q   <= '0;
            cnt       <= '0;
            reg_we    <= 1'b0;
            flag_we   <= 1'b0;
            reg_wdata <= '0;
        end else begin
            reg_we  <= 1'b0;
            flag_we <= 1'b0;
            case (state)
                S_IDLE: begin
                    cnt <= '0;
                    if (Run) state <= S_FETCH;
                end
                S_FETCH: begin
                    if (lat_done) begin
                        instr_q <= bus.Imem_Data;
                        cnt     <= '0;
                        state   <= S_EXEC;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                S_EXEC: begin
                    if (is_halt) begin
                        state <= S_HALT;
                    end else if ((is_ldr || is_str) && bus.Cond_Pass) begin
                        cnt   <= '0;
                        state <= S_MEM;
                    end else begin
                        // failed-condition loads/stores skip the data port entirely
                        reg_we    <= bus.Cond_Pass & is_alu;
                        flag_we   <= bus.Cond_Pass & is_alu & instr_q[S_BIT];
                        reg_wdata <= bus.Alu_Result;
                        state     <= S_WB;
                    end
                end
                S_MEM: begin
                    if (lat_done) begin
                        cnt   <= '0;
                        state <= S_WB;
                        if (is_ldr) begin
                            reg_we    <= 1'b1;
                            reg_wdata <= bus.Dmem_RData;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                S_WB: begin
                    pc    <= pc_next;
                    state <= Run ? S_FETCH : S_IDLE;
                end
                S_HALT: state <= S_HALT;
                default: state <= S_IDLE;
            endcase
        end
    end

    assign Halted = (state == S_HALT);
    assign Busy   = (state != S_IDLE) && (state != S_HALT);

    assign bus.Imem_En   = (state == S_FETCH);
    assign bus.Imem_Addr = pc;
    assign bus.Instr     = instr_q;
    assign bus.Reg_We    = reg_we;
    assign bus.Reg_WData = reg_wdata;
    assign bus.Flag_We   = flag_we;

    // Preload owns the data port whenever the CPU is not in MEM; held off while halted
    assign cpu_mem = (state == S_MEM);
    assign ld_gnt  = bus.Ld_Req && Reset_n && !cpu_mem && (state != S_HALT);

    assign bus.Ld_Gnt     = ld_gnt;
    assign bus.Dmem_En    = cpu_mem || ld_gnt;
    assign bus.Dmem_RW    = cpu_mem && is_ldr;
    assign bus.Dmem_Addr  = cpu_mem ? bus.Alu_Result[DADDR_W-1:0] :
                            ld_gnt  ? bus.Ld_Addr : '0;
    assign bus.Dmem_WData = (cpu_mem && is_str) ? bus.Store_Data :
                            (!cpu_mem && ld_gnt) ? bus.Ld_Data : '0;
endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed bench for cpu_sequencer: behavioural RAMs/ALU, scoreboard queues for fetches, writebacks and data-port traffic.
module tb_cpu_sequencer;
    localparam int PC_W = 8, DADDR_W = 16, MEM_LAT = 1;

    logic Clk = 1'b0;
    logic Reset_n = 1'b0;
    logic Run = 1'b0;
    logic Halted, Busy;

    cpu_sequencer_if #(.PC_W(PC_W), .DADDR_W(DADDR_W)) bus ();

    cpu_sequencer #(.PC_W(PC_W), .DADDR_W(DADDR_W), .MEM_LAT(MEM_LAT)) dut (
        .Clk(Clk), .Reset_n(Reset_n), .Run(Run), .Halted(Halted), .Busy(Busy), .bus(bus)
    );

    always #5 Clk = ~Clk;

    logic [31:0] imem [0:255];
    logic [31:0] dmem [0:255];

    // Datapath model: cond 4'hE passes, anything else fails; result is the 16-bit immediate
    assign bus.Imem_Data  = imem[bus.Imem_Addr];
    assign bus.Cond_Pass  = (bus.Instr[31:28] == 4'hE);
    assign bus.Alu_Result = {16'h0, bus.Instr[15:0]};
    assign bus.Store_Data = {bus.Instr[15:0], 16'h5A5A};
    assign bus.Dmem_RData = dmem[bus.Dmem_Addr[7:0]];

    always @(posedge Clk)
        if (bus.Dmem_En && !bus.Dmem_RW) dmem[bus.Dmem_Addr[7:0]] = bus.Dmem_WData;

    typedef struct packed { logic rw; logic [15:0] addr; logic [31:0] data; } dm_ev_t;
    typedef struct packed { logic reg_we; logic flag_we; logic [31:0] data; } wb_ev_t;

    dm_ev_t     dm_q[$];
    wb_ev_t     wb_q[$];
    logic [7:0] if_q[$];
    int n_chk = 0;
    int n_fail = 0;
    logic ien_q = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mk(input logic [3:0] c, input logic [3:0] op,
                                       input logic s, input logic [15:0] imm);
        return {c, op, s, 7'd0, imm};
    endfunction

    // Scoreboard side: pop expected events as the DUT produces them
    always @(negedge Clk) begin
        if (Reset_n) begin
            if (bus.Imem_En && !ien_q) begin
                if (if_q.size() == 0) chk("fetch_unexpected", 64'(if_q.size()), 64'd1);
                else chk("fetch_addr", 64'(bus.Imem_Addr), 64'(if_q.pop_front()));
            end
            if (bus.Reg_We || bus.Flag_We) begin
                if (wb_q.size() == 0) chk("wb_unexpected", 64'(wb_q.size()), 64'd1);
                else chk("wb_event", 64'({bus.Reg_We, bus.Flag_We, bus.Reg_WData}),
                         64'(wb_q.pop_front()));
            end
            if (bus.Dmem_En) begin
                if (dm_q.size() == 0) chk("dmem_unexpected", 64'(dm_q.size()), 64'd1);
                else chk("dmem_event",
                         64'({bus.Dmem_RW, bus.Dmem_Addr, bus.Dmem_RW ? 32'h0 : bus.Dmem_WData}),
                         64'(dm_q.pop_front()));
            end
        end
        ien_q = bus.Imem_En && Reset_n;
    end

    task automatic do_reset();
        Reset_n = 1'b0;
        Run = 1'b0;
        bus.Ld_Req = 1'b1;
        bus.Ld_Addr = 16'h0044;
        bus.Ld_Data = 32'hDEAD0000;
        #2;
        chk("rst_status", 64'({Halted, Busy}), 64'd0);
        chk("rst_imem", 64'({bus.Imem_En, bus.Imem_Addr}), 64'd0);
        chk("rst_instr", 64'(bus.Instr), 64'd0);
        chk("rst_wb", 64'({bus.Reg_We, bus.Flag_We, bus.Reg_WData}), 64'd0);
        chk("rst_dmem", 64'({bus.Dmem_En, bus.Ld_Gnt}), 64'd0);
        bus.Ld_Req = 1'b0;
        @(posedge Clk); #1;
        Reset_n = 1'b1;
    endtask

    task automatic preload(input logic [15:0] a, input logic [31:0] d);
        @(posedge Clk); #1;
        bus.Ld_Req = 1'b1;
        bus.Ld_Addr = a;
        bus.Ld_Data = d;
        dm_q.push_back({1'b0, a, d});
        @(negedge Clk);
        chk("preload_gnt", 64'(bus.Ld_Gnt), 64'd1);
        @(posedge Clk); #1;
        bus.Ld_Req = 1'b0;
    endtask

    task automatic wait_halt(input int bound);
        int n;
        n = 0;
        while (!Halted && n < bound) begin
            @(negedge Clk);
            n++;
        end
        chk("halt_reached", 64'(Halted), 64'd1);
    endtask

    task automatic drain(input string tag);
        chk({tag, "_fetch_left"}, 64'(if_q.size()), 64'd0);
        chk({tag, "_wb_left"}, 64'(wb_q.size()), 64'd0);
        chk({tag, "_dmem_left"}, 64'(dm_q.size()), 64'd0);
        if_q.delete();
        wb_q.delete();
        dm_q.delete();
    endtask

    task automatic clear_mems();
        for (int i = 0; i < 256; i++) begin
            imem[i] = mk(4'h0, 4'h1, 1'b0, 16'h0);
            dmem[i] = 32'h0;
        end
    endtask

    initial begin
        int n;
        bus.Ld_Req = 1'b0;
        bus.Ld_Addr = '0;
        bus.Ld_Data = '0;
        clear_mems();

        // ---- Program A: ALU, LDR, failed STR, NOP, STR, ALU, failed ALU, HALT
        do_reset();
        @(negedge Clk);
        chk("idle_busy", 64'(Busy), 64'd0);
        imem[0] = mk(4'hE, 4'h0, 1'b1, 16'd20);
        imem[1] = mk(4'hE, 4'hD, 1'b0, 16'd5);
        imem[2] = mk(4'h0, 4'hE, 1'b0, 16'd3);
        imem[3] = mk(4'hE, 4'hC, 1'b0, 16'h0);
        imem[4] = mk(4'hE, 4'hE, 1'b0, 16'd3);
        imem[5] = mk(4'hE, 4'h2, 1'b0, 16'h77);
        imem[6] = mk(4'h0, 4'h3, 1'b1, 16'h99);
        imem[7] = mk(4'hE, 4'hF, 1'b0, 16'h0);
        preload(16'd5, 32'hAAA5);
        for (int i = 0; i < 8; i++) if_q.push_back(8'(i));
        wb_q.push_back({1'b1, 1'b1, 32'd20});
        wb_q.push_back({1'b1, 1'b0, 32'hAAA5});
        wb_q.push_back({1'b1, 1'b0, 32'h77});
        dm_q.push_back({1'b1, 16'd5, 32'h0});
        dm_q.push_back({1'b0, 16'd3, 32'h00035A5A});
        @(posedge Clk); #1;
        Run = 1'b1;
        repeat (2) @(negedge Clk);
        chk("c1_fetch", 64'({bus.Imem_En, bus.Imem_Addr, Busy}), 64'({1'b1, 8'd0, 1'b1}));
        chk("c1_instr_reset_val", 64'(bus.Instr), 64'd0);
        @(negedge Clk);
        chk("c2_instr", 64'(bus.Instr), 64'(imem[0]));
        chk("c2_no_we", 64'(bus.Reg_We), 64'd0);
        @(negedge Clk);
        chk("c3_reg_we", 64'({bus.Reg_We, bus.Reg_WData}), 64'({1'b1, 32'd20}));
        @(negedge Clk);
        chk("c4_next_pc", 64'({bus.Imem_En, bus.Imem_Addr}), 64'({1'b1, 8'd1}));
        wait_halt(200);
        chk("a_halt_busy", 64'(Busy), 64'd0);
        chk("a_store_landed", 64'(dmem[3]), 64'h00035A5A);
        repeat (5) @(negedge Clk);
        chk("a_halt_sticky", 64'({Halted, bus.Imem_En, bus.Imem_Addr}), 64'({1'b1, 1'b0, 8'd7}));
        drain("a");
        Reset_n = 1'b0;
        #1;
        chk("halt_cleared", 64'(Halted), 64'd0);

        // ---- Program B: preload held off during STR MEM cycle
        clear_mems();
        do_reset();
        imem[0] = mk(4'hE, 4'hE, 1'b0, 16'h13);
        imem[1] = mk(4'hE, 4'hF, 1'b0, 16'h0);
        if_q.push_back(8'd0);
        if_q.push_back(8'd1);
        dm_q.push_back({1'b0, 16'h13, 32'h00135A5A});
        dm_q.push_back({1'b0, 16'h9, 32'h1234});
        @(posedge Clk); #1;
        Run = 1'b1;
        repeat (3) @(posedge Clk); #1;
        bus.Ld_Req = 1'b1;
        bus.Ld_Addr = 16'h9;
        bus.Ld_Data = 32'h1234;
        @(negedge Clk);
        chk("b_mem_gnt", 64'({bus.Ld_Gnt, bus.Dmem_En, bus.Dmem_RW, bus.Dmem_Addr}),
            64'({1'b0, 1'b1, 1'b0, 16'h13}));
        @(negedge Clk);
        chk("b_wb_gnt", 64'({bus.Ld_Gnt, bus.Dmem_Addr}), 64'({1'b1, 16'h9}));
        @(posedge Clk); #1;
        bus.Ld_Req = 1'b0;
        wait_halt(50);
        chk("b_cpu_write", 64'(dmem[8'h13]), 64'h00135A5A);
        chk("b_ld_write", 64'(dmem[8'h09]), 64'h1234);
        drain("b");

        // ---- Reset during MEM: no store completes
        clear_mems();
        do_reset();
        imem[0] = mk(4'hE, 4'hE, 1'b0, 16'h21);
        if_q.push_back(8'd0);
        dm_q.push_back({1'b0, 16'h21, 32'h00215A5A});
        @(posedge Clk); #1;
        Run = 1'b1;
        repeat (3) @(posedge Clk); #1;
        @(negedge Clk);
        #1;
        Reset_n = 1'b0;
        #1;
        chk("rst_mid_mem_en", 64'(bus.Dmem_En), 64'd0);
        @(posedge Clk); #1;
        chk("rst_mid_mem_nowrite", 64'(dmem[8'h21]), 64'd0);
        drain("r");

        // ---- Program C: PC wrap, Run dropped mid-instruction, then HALT
        clear_mems();
        do_reset();
        imem[0]   = mk(4'hE, 4'h1, 1'b0, 16'h11);
        imem[255] = mk(4'hE, 4'h4, 1'b1, 16'h42);
        for (int i = 0; i < 256; i++) if_q.push_back(8'(i));
        wb_q.push_back({1'b1, 1'b0, 32'h11});
        wb_q.push_back({1'b1, 1'b1, 32'h42});
        @(posedge Clk); #1;
        Run = 1'b1;
        n = 0;
        while (!(bus.Imem_En && bus.Imem_Addr == 8'hFF) && n < 2000) begin
            @(negedge Clk);
            n++;
        end
        chk("c_reach_ff", 64'({bus.Imem_En, bus.Imem_Addr}), 64'({1'b1, 8'hFF}));
        @(posedge Clk); #1;
        Run = 1'b0;
        n = 0;
        while (Busy && n < 20) begin
            @(negedge Clk);
            n++;
        end
        chk("c_idle_after_drop", 64'({Busy, Halted}), 64'd0);
        chk("c_pc_wrap", 64'(bus.Imem_Addr), 64'd0);
        repeat (3) @(negedge Clk);
        chk("c_stays_idle", 64'({Busy, bus.Imem_En}), 64'd0);
        imem[1] = mk(4'hE, 4'hF, 1'b0, 16'h0);
        if_q.push_back(8'd0);
        if_q.push_back(8'd1);
        wb_q.push_back({1'b1, 1'b0, 32'h11});
        @(posedge Clk); #1;
        Run = 1'b1;
        wait_halt(50);
        chk("c_halt_pc", 64'(bus.Imem_Addr), 64'd1);
        drain("c");

        // ---- Program D: opcode C, branch or NOP depending on build
        clear_mems();
        do_reset();
        imem[0] = mk(4'hE, 4'hC, 1'b0, 16'h0038);
        imem[1] = mk(4'hE, 4'hF, 1'b0, 16'h0);
        imem[7] = mk(4'hE, 4'hF, 1'b0, 16'h0);
        if_q.push_back(8'd0);
`ifdef CPU_SEQ_BRANCH_EN
        if_q.push_back(8'd7);
`else
        if_q.push_back(8'd1);
`endif
        @(posedge Clk); #1;
        Run = 1'b1;
        wait_halt(50);
`ifdef CPU_SEQ_BRANCH_EN
        chk("d_branch_pc", 64'(bus.Imem_Addr), 64'd7);
`else
        chk("d_nop_pc", 64'(bus.Imem_Addr), 64'd1);
`endif
        drain("d");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
